shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 86 ++++++++
 tb/tb_shift_add_multiplier.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// fixed DATA_WIDTH-cycle latency, start/busy/done handshake, low word + overflow flag.
module shift_add_multiplier #(
  parameter int unsigned DATA_WIDTH  = 20,
  parameter int unsigned COUNT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product,
  output logic                  overflow
);

  localparam int unsigned AccWidth = 2 * DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LastCnt = COUNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 r_state;
  logic [AccWidth-1:0]    r_acc;
  logic [AccWidth-1:0]    r_mcand;
  logic [DATA_WIDTH-1:0]  r_mplier;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [AccWidth-1:0]    w_acc_next;

  // Full-width accumulate so the final step can report overflow without truncation.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            r_mcand  <= {{DATA_WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            product  <= w_acc_next[DATA_WIDTH-1:0];
            overflow <= |w_acc_next[AccWidth-1:DATA_WIDTH];
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected results are queued at accept
// and compared (value, overflow, latency) whenever the DUT pulses done.
module tb_shift_add_multiplier;

  localparam int W       = 20;
  localparam int Latency = 20;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic         overflow;

  shift_add_multiplier #(
    .DATA_WIDTH (W),
    .COUNT_WIDTH(5)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] p;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Call at negedge+1; the next rising edge is the accept edge.
  task automatic push_exp(input logic [W-1:0] xa, input logic [W-1:0] xb);
    logic [2*W-1:0] full;
    exp_t e;
    full      = {{W{1'b0}}, xa} * {{W{1'b0}}, xb};
    e.p       = full[W-1:0];
    e.ovf     = |full[2*W-1:W];
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
    @(negedge clk);
    #1;
    start = 1'b1;
    a     = xa;
    b     = xb;
    push_exp(xa, xb);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    check("timeout", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("busy_with_done", 64'(busy), 64'd0);
        check("done_twice", 64'(prev_done), 64'd0);
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("product", 64'(product), 64'(e.p));
          check("overflow", 64'(overflow), 64'(e.ovf));
          check("latency", 64'(cyc - e.acc_cyc), 64'(Latency));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    int nbusy;
    int first_done_cyc;

    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_product", 64'(product), 64'd0);

    // 1: basic multiply, busy for exactly Latency cycles
    start_op(20'd3, 20'd5);
    nbusy = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #2;
      if (busy) nbusy++;
    end
    check("busy_cycles", 64'(nbusy), 64'(Latency));
    wait_idle();
    check("t1_product", 64'(product), 64'h0000F);

    // 2: large operands and overflow boundaries
    start_op(20'd1000, 20'd1000);
    wait_idle();
    check("t2a_product", 64'(product), 64'hF4240);
    start_op(20'hFFFFF, 20'hFFFFF);
    wait_idle();
    check("t2b_overflow", 64'(overflow), 64'd1);
    start_op(20'h80000, 20'd2);
    wait_idle();
    check("t2c_product", 64'(product), 64'd0);

    // 3: zero operands still take full latency
    start_op(20'd0, 20'hABCDE);
    wait_idle();
    start_op(20'hABCDE, 20'd0);
    wait_idle();

    // 4: start during RUN is ignored
    start_op(20'd7, 20'd6);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      start = 1'b1;
      a     = (i == 0) ? 20'd9 : W'($urandom);
      b     = (i == 0) ? 20'd9 : W'($urandom);
      #2;
      check("t4_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    #1 start = 1'b0;
    wait_idle();
    check("t4_product", 64'(product), 64'h0002A);

    // 5: start held high; back-to-back accept in the DONE cycle
    @(negedge clk);
    #1;
    start = 1'b1;
    a     = 20'd2;
    b     = 20'd3;
    push_exp(20'd2, 20'd3);
    first_done_cyc = -1;
    for (int i = 0; i < 40 && first_done_cyc < 0; i++) begin
      @(negedge clk);
      #2;
      if (done) first_done_cyc = cyc;
    end
    check("t5_first_done_seen", 64'(first_done_cyc >= 0), 64'd1);
    a = 20'd4;
    b = 20'd5;
    push_exp(20'd4, 20'd5);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check("t5_hold_product", 64'(product), 64'd6);
    end
    wait_idle();
    check("t5_product", 64'(product), 64'd20);

    // 6: asynchronous reset mid-operation
    start_op(20'h12345, 20'h10);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_product", 64'(product), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("t6_quiet_busy", 64'(busy), 64'd0);
    check("t6_quiet_product", 64'(product), 64'd0);
    start_op(20'd2, 20'd2);
    wait_idle();
    check("t6_product_after", 64'(product), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
